// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle between ID/EX and the execute unit.
// slave is the execute unit's view; master is the upstream/downstream side.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ALUCtl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             lt_o;

  modport slave (
    input  valid_i, ALUCtl_i, data1_i, data2_i, ready_i,
    output ready_o, valid_o, data_o, zero_o, lt_o
  );

  modport master (
    output valid_i, ALUCtl_i, data1_i, data2_i, ready_i,
    input  ready_o, valid_o, data_o, zero_o, lt_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: single-cycle ALU ops plus an iterative shift-add
// multiplier, with valid/ready handshakes on both sides.
//
//   state  | meaning
//   IDLE   | no result held, ready for a request
//   MUL    | shift-add multiply in progress, upstream stalled
//   DONE   | result held on data_o until downstream takes it
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_exec_unit_if.slave  bus
);

  localparam logic [3:0] ALU_CTL_ADD  = 4'd0;
  localparam logic [3:0] ALU_CTL_SUB  = 4'd1;
  localparam logic [3:0] ALU_CTL_SUBU = 4'd2;
  localparam logic [3:0] ALU_CTL_SLL  = 4'd3;
  localparam logic [3:0] ALU_CTL_SRL  = 4'd4;
  localparam logic [3:0] ALU_CTL_SRA  = 4'd5;
  localparam logic [3:0] ALU_CTL_XOR  = 4'd6;
  localparam logic [3:0] ALU_CTL_AND  = 4'd7;
  localparam logic [3:0] ALU_CTL_MUL  = 4'd8;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_lt;
  logic             r_valid;

  logic             w_ready;
  logic             w_accept;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_lt;
  logic [WIDTH-1:0] w_acc_next;

  assign w_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.ready_i);
  assign w_accept   = bus.valid_i && w_ready;
  assign w_shamt    = bus.data2_i[4:0];
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.zero_o  = r_zero;
  assign bus.lt_o    = r_lt;

  // Single-cycle result for the op presented on the inputs; unknown codes add.
  always_comb begin
    w_res = bus.data1_i + bus.data2_i;
    w_lt  = 1'b0;
    case (bus.ALUCtl_i)
      ALU_CTL_SUB: begin
        w_res = bus.data1_i - bus.data2_i;
        w_lt  = $signed(bus.data1_i) < $signed(bus.data2_i);
      end
      ALU_CTL_SUBU: begin
        w_res = bus.data1_i - bus.data2_i;
        w_lt  = bus.data1_i < bus.data2_i;
      end
      ALU_CTL_SLL: w_res = bus.data1_i << w_shamt;
      ALU_CTL_SRL: w_res = bus.data1_i >> w_shamt;
      ALU_CTL_SRA: w_res = $unsigned($signed(bus.data1_i) >>> w_shamt);
      ALU_CTL_XOR: w_res = bus.data1_i ^ bus.data2_i;
      ALU_CTL_AND: w_res = bus.data1_i & bus.data2_i;
      default:     w_res = bus.data1_i + bus.data2_i;
    endcase
  end

  // Control FSM, multiplier datapath and registered result outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_data  <= w_acc_next;
            r_zero  <= (w_acc_next == '0);
            r_lt    <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            if (bus.ALUCtl_i == ALU_CTL_MUL) begin
              r_acc    <= '0;
              r_mcand  <= bus.data1_i;
              r_mplier <= bus.data2_i;
              r_cnt    <= CW'(WIDTH);
              r_valid  <= 1'b0;
              r_state  <= S_MUL;
            end else begin
              r_data  <= w_res;
              r_zero  <= (w_res == '0);
              r_lt    <= w_lt;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end
          end else if ((r_state == S_DONE) && bus.ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
